// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master register-transaction sequencer:
// FSM states, completion codes, RW bit values and byte-controller command encodings.
package i2c_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEV_W,
      ST_REG,
      ST_WDATA,
      ST_DEV_R,
      ST_RDATA,
      ST_STOP,
      ST_DONE
   } xfer_state_e;

   localparam logic [1:0] XFER_ERR_OK   = 2'b00;
   localparam logic [1:0] XFER_ERR_ADDR = 2'b01;
   localparam logic [1:0] XFER_ERR_DATA = 2'b10;
   localparam logic [1:0] XFER_ERR_AL   = 2'b11;

   localparam logic I2C_WR = 1'b0;
   localparam logic I2C_RD = 1'b1;

   typedef struct packed {
      logic start;
      logic stop;
      logic read;
      logic write;
   } byte_cmd_t;

   localparam byte_cmd_t CMD_NONE     = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b0};
   localparam byte_cmd_t CMD_START_WR = '{start: 1'b1, stop: 1'b0, read: 1'b0, write: 1'b1};
   localparam byte_cmd_t CMD_WR       = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b1};
   localparam byte_cmd_t CMD_STOP     = '{start: 1'b0, stop: 1'b1, read: 1'b0, write: 1'b0};

   // Data-phase command: a read or a write byte, optionally closing the transfer with stop.
   function automatic byte_cmd_t data_cmd(input logic rd, input logic stop);
      return '{start: 1'b0, stop: stop, read: rd, write: !rd};
   endfunction

endpackage

// File: rtl/i2c_master_xfer_seq_if.sv
// Signal bundle between system logic, the transaction sequencer and the I2C byte controller.
// slave = the sequencer itself; master = the requester plus byte controller around it.
interface i2c_master_xfer_seq_if;

   logic        req_valid_i;
   logic        req_ready_o;
   logic [6:0]  req_dev_i;
   logic [7:0]  req_reg_i;
   logic        req_rnw_i;
   logic [1:0]  req_len_i;
   logic [31:0] req_wdata_i;

   logic        rsp_done_o;
   logic [1:0]  rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        busy_o;

   logic        byte_start_o;
   logic        byte_stop_o;
   logic        byte_read_o;
   logic        byte_write_o;
   logic        byte_ack_o;
   logic [7:0]  byte_dat_o;
   logic        byte_cmd_ack_i;
   logic        byte_ack_i;
   logic [7:0]  byte_dat_i;
   logic        byte_al_i;

   modport slave (
      input  req_valid_i, req_dev_i, req_reg_i, req_rnw_i, req_len_i, req_wdata_i,
      output req_ready_o, rsp_done_o, rsp_err_o, rsp_rdata_o, busy_o,
      output byte_start_o, byte_stop_o, byte_read_o, byte_write_o, byte_ack_o, byte_dat_o,
      input  byte_cmd_ack_i, byte_ack_i, byte_dat_i, byte_al_i
   );

   modport master (
      output req_valid_i, req_dev_i, req_reg_i, req_rnw_i, req_len_i, req_wdata_i,
      input  req_ready_o, rsp_done_o, rsp_err_o, rsp_rdata_o, busy_o,
      input  byte_start_o, byte_stop_o, byte_read_o, byte_write_o, byte_ack_o, byte_dat_o,
      output byte_cmd_ack_i, byte_ack_i, byte_dat_i, byte_al_i
   );

endinterface

// File: rtl/i2c_master_xfer_seq.sv
// Expands one register-level request into the I2C byte-controller command sequence.
// Define I2C_XFER_RETRY_EN to retry once (stop, then restart) on the first address NACK.
module i2c_master_xfer_seq
   import i2c_master_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   i2c_master_xfer_seq_if.slave bus
);

   xfer_state_e state_q;
   byte_cmd_t   cmd_q;
   logic [6:0]  dev_q;
   logic [7:0]  reg_q;
   logic        rnw_q;
   logic [1:0]  len_q;
   logic [31:0] wdata_q;
   logic [1:0]  idx_q;
   logic [1:0]  err_q;
   logic [31:0] rdata_q;
   logic [7:0]  dat_q;
   logic        ack_q;
`ifdef I2C_XFER_RETRY_EN
   logic        retry_q;
`endif

   logic       ready;
   logic       accept;
   logic       last;
   logic       nack;
   logic [1:0] idx_nxt;
   logic       last_nxt;

   // DONE doubles as an accepting state so a held request starts in the done-pulse cycle.
   assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign accept   = bus.req_valid_i && ready;
   assign last     = (idx_q == len_q);
   assign nack     = bus.byte_ack_i;
   assign idx_nxt  = idx_q + 2'd1;
   assign last_nxt = (idx_nxt == len_q);

   // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cmd_q   <= CMD_NONE;
         dev_q   <= '0;
         reg_q   <= '0;
         rnw_q   <= 1'b0;
         len_q   <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
         err_q   <= XFER_ERR_OK;
         rdata_q <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
`ifdef I2C_XFER_RETRY_EN
         retry_q <= 1'b0;
`endif
      end else if (accept) begin
         state_q <= ST_DEV_W;
         cmd_q   <= CMD_START_WR;
         dat_q   <= {bus.req_dev_i, I2C_WR};
         ack_q   <= 1'b0;
         dev_q   <= bus.req_dev_i;
         reg_q   <= bus.req_reg_i;
         rnw_q   <= bus.req_rnw_i;
         len_q   <= bus.req_len_i;
         wdata_q <= bus.req_wdata_i;
         idx_q   <= '0;
         err_q   <= XFER_ERR_OK;
         rdata_q <= '0;
`ifdef I2C_XFER_RETRY_EN
         retry_q <= 1'b0;
`endif
      end else if (ready) begin
         state_q <= ST_IDLE;
      end else if (bus.byte_al_i) begin
         // The byte controller has already released the bus, so no stop follows.
         cmd_q   <= CMD_NONE;
         err_q   <= XFER_ERR_AL;
         state_q <= ST_DONE;
      end else if (bus.byte_cmd_ack_i) begin
         cmd_q <= CMD_NONE;
         case (state_q)
            ST_DEV_W, ST_DEV_R: begin
               if (nack) begin
                  state_q <= ST_STOP;
                  cmd_q   <= CMD_STOP;
`ifdef I2C_XFER_RETRY_EN
                  retry_q <= 1'b1;
                  if (retry_q) err_q <= XFER_ERR_ADDR;
`else
                  err_q   <= XFER_ERR_ADDR;
`endif
               end else if (state_q == ST_DEV_W) begin
                  state_q <= ST_REG;
                  cmd_q   <= CMD_WR;
                  dat_q   <= reg_q;
               end else begin
                  state_q <= ST_RDATA;
                  cmd_q   <= data_cmd(I2C_RD, last);
                  ack_q   <= last;
               end
            end
            ST_REG: begin
               if (nack) begin
                  err_q   <= XFER_ERR_DATA;
                  state_q <= ST_STOP;
                  cmd_q   <= CMD_STOP;
               end else if (rnw_q) begin
                  state_q <= ST_DEV_R;
                  cmd_q   <= CMD_START_WR;
                  dat_q   <= {dev_q, I2C_RD};
               end else begin
                  state_q <= ST_WDATA;
                  cmd_q   <= data_cmd(I2C_WR, last);
                  dat_q   <= wdata_q[7:0];
               end
            end
            ST_WDATA: begin
               if (last) begin
                  state_q <= ST_DONE;
                  if (nack) err_q <= XFER_ERR_DATA;
               end else if (nack) begin
                  err_q   <= XFER_ERR_DATA;
                  state_q <= ST_STOP;
                  cmd_q   <= CMD_STOP;
               end else begin
                  idx_q <= idx_nxt;
                  cmd_q <= data_cmd(I2C_WR, last_nxt);
                  dat_q <= wdata_q[{idx_nxt, 3'b000} +: 8];
               end
            end
            ST_RDATA: begin
               rdata_q[{idx_q, 3'b000} +: 8] <= bus.byte_dat_i;
               if (last) begin
                  state_q <= ST_DONE;
               end else begin
                  idx_q <= idx_nxt;
                  cmd_q <= data_cmd(I2C_RD, last_nxt);
                  ack_q <= last_nxt;
               end
            end
            ST_STOP: begin
               state_q <= ST_DONE;
`ifdef I2C_XFER_RETRY_EN
               // Only the first address NACK reaches STOP with no error recorded: restart.
               if (err_q == XFER_ERR_OK) begin
                  state_q <= ST_DEV_W;
                  cmd_q   <= CMD_START_WR;
                  dat_q   <= {dev_q, I2C_WR};
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o  = ready;
   assign bus.busy_o       = !ready;
   assign bus.rsp_done_o   = (state_q == ST_DONE);
   assign bus.rsp_err_o    = err_q;
   assign bus.rsp_rdata_o  = rdata_q;
   assign bus.byte_start_o = cmd_q.start;
   assign bus.byte_stop_o  = cmd_q.stop;
   assign bus.byte_read_o  = cmd_q.read;
   assign bus.byte_write_o = cmd_q.write;
   assign bus.byte_ack_o   = ack_q;
   assign bus.byte_dat_o   = dat_q;

endmodule
